// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: types and constants shared by the mac_seq_ctrl slice.
//   state_t      - sequencer FSM states
//   OUTW_DEFAULT - default MAC accumulator width (shared with mac)
//   INW_DEFAULT  - default MAC operand width (shared with mac)
//   cnt_width()  - counter width helper that never returns zero
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    OUTPUT
  } state_t;

  localparam int unsigned OUTW_DEFAULT = 48;
  localparam int unsigned INW_DEFAULT  = 16;

  // Width needed to count 0..n-1, with a minimum of one bit for n <= 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_seq_addr_gen.sv
// mac_seq_addr_gen: row/column counters and memory address generation
// for the mac_seq_ctrl sequencer.
//   clk, reset       - clock, synchronous active-high reset
//   row_clr, row_inc - zero / advance the row counter (clear wins)
//   col_clr, col_inc - zero / advance the column counter (clear wins)
//   row, col         - current counter values
//   last_row         - row == M-1
//   last_col         - col == N-1
//   addr_w           - W address, row*N + col
//   addr_x           - x address, col
module mac_seq_addr_gen
  import mac_seq_pkg::*;
#(
  parameter int unsigned M   = 4,
  parameter int unsigned N   = 4,
  parameter int unsigned AWW = $clog2(M * N),
  parameter int unsigned AWX = $clog2(N),
  parameter int unsigned RW  = cnt_width(M)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           row_clr,
  input  logic           row_inc,
  input  logic           col_clr,
  input  logic           col_inc,
  output logic [RW-1:0]  row,
  output logic [AWX-1:0] col,
  output logic           last_row,
  output logic           last_col,
  output logic [AWW-1:0] addr_w,
  output logic [AWX-1:0] addr_x
);

  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else begin
      if (row_clr)
        row <= '0;
      else if (row_inc)
        row <= row + RW'(1);

      if (col_clr)
        col <= '0;
      else if (col_inc)
        col <= col + AWX'(1);
    end
  end

  assign last_row = (row == RW'(M - 1));
  assign last_col = (col == AWX'(N - 1));

  // Counters are registered and only change on the controller's say-so,
  // so the addresses hold whenever the counters hold.
  assign addr_w = AWW'(row) * AWW'(N) + AWW'(col);
  assign addr_x = col;

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one mac instance to compute y = W*x, one
// accumulated result per matrix row, returned over valid/ready.
//   clk, reset       - clock, synchronous active-high reset
//   start            - begin a run (sampled only while idle)
//   busy             - high in every state except IDLE
//   done             - pulse on the final row's output handshake
//   addr_w, addr_x   - W / x memory read addresses (1-cycle read latency)
//   mac_clear_acc    - to mac.clear_acc
//   mac_valid_input  - to mac.valid_input
//   mac_out          - from mac.out
//   out_data         - row result (0 when out_valid is low)
//   out_valid        - result available
//   out_ready        - downstream accepts result
// Build option: define MAC_SEQ_CTRL_RELU_EN to clamp negative results to 0.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int unsigned M    = 4,
  parameter int unsigned N    = 4,
  parameter int unsigned OUTW = OUTW_DEFAULT,
  parameter int unsigned AWW  = $clog2(M * N),
  parameter int unsigned AWX  = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AWW-1:0]  addr_w,
  output logic [AWX-1:0]  addr_x,
  output logic            mac_clear_acc,
  output logic            mac_valid_input,
  input  logic [OUTW-1:0] mac_out,
  output logic [OUTW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int unsigned RW = cnt_width(M);

  state_t         state;
  logic           busy_q;
  logic           clear_q;
  logic           vin_q;
  logic           ovalid_q;

  logic           row_clr;
  logic           row_inc;
  logic           col_clr;
  logic           col_inc;
  logic           last_row;
  logic           last_col;
  logic [RW-1:0]  row;
  logic [AWX-1:0] col;
  logic           handshake;

  mac_seq_addr_gen #(
    .M   (M),
    .N   (N),
    .AWW (AWW),
    .AWX (AWX),
    .RW  (RW)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .row_clr  (row_clr),
    .row_inc  (row_inc),
    .col_clr  (col_clr),
    .col_inc  (col_inc),
    .row      (row),
    .col      (col),
    .last_row (last_row),
    .last_col (last_col),
    .addr_w   (addr_w),
    .addr_x   (addr_x)
  );

  // Counter control. col stops at N-1 so the addresses hold through
  // DRAIN and OUTPUT.
  always_comb begin
    row_clr = 1'b0;
    row_inc = 1'b0;
    col_clr = 1'b0;
    col_inc = 1'b0;
    unique case (state)
      IDLE:    row_clr = start;
      CLEAR:   col_clr = 1'b1;
      RUN:     col_inc = !last_col;
      OUTPUT:  row_inc = out_ready && !last_row;
      default: ;
    endcase
  end

  // ovalid_q is high exactly while in OUTPUT.
  assign handshake = ovalid_q && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      clear_q  <= 1'b0;
      vin_q    <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      // Read data lags the RUN address by one cycle.
      vin_q <= (state == RUN);
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            busy_q  <= 1'b1;
            clear_q <= 1'b1;
          end
        end
        CLEAR: begin
          state   <= RUN;
          clear_q <= 1'b0;
        end
        RUN: begin
          if (last_col)
            state <= DRAIN;
        end
        DRAIN: begin
          state    <= OUTPUT;
          ovalid_q <= 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            ovalid_q <= 1'b0;
            if (last_row) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state   <= CLEAR;
              clear_q <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          clear_q  <= 1'b0;
          ovalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign mac_clear_acc   = clear_q;
  assign mac_valid_input = vin_q;
  assign out_valid       = ovalid_q;
  assign done            = handshake && last_row;

`ifdef MAC_SEQ_CTRL_RELU_EN
  assign out_data = (ovalid_q && !mac_out[OUTW-1]) ? mac_out : '0;
`else
  assign out_data = ovalid_q ? mac_out : '0;
`endif

  a_ctrl_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(mac_clear_acc && mac_valid_input));

  a_counters_in_range: assert property (@(posedge clk) disable iff (reset)
    (int'(row) < int'(M)) && (int'(col) < int'(N)));

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

  localparam int unsigned M    = 2;
  localparam int unsigned N    = 3;
  localparam int unsigned OUTW = 48;
  localparam int unsigned AWW  = $clog2(M * N);
  localparam int unsigned AWX  = $clog2(N);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            out_ready = 1'b0;
  logic            busy, done, mac_clear_acc, mac_valid_input, out_valid;
  logic [AWW-1:0]  addr_w;
  logic [AWX-1:0]  addr_x;
  logic [OUTW-1:0] mac_out, out_data;

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .M    (M),
    .N    (N),
    .OUTW (OUTW),
    .AWW  (AWW),
    .AWX  (AWX)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .addr_w          (addr_w),
    .addr_x          (addr_x),
    .mac_clear_acc   (mac_clear_acc),
    .mac_valid_input (mac_valid_input),
    .mac_out         (mac_out),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  // Environment: synchronous-read memories and a MAC.
  longint wmem [0:7];
  longint xmem [0:3];
  longint w_q, x_q;
  logic signed [63:0] acc;

  always @(posedge clk) begin
    w_q <= wmem[addr_w];
    x_q <= xmem[addr_x];
    if (reset)              acc <= '0;
    else if (mac_clear_acc) acc <= '0;
    else if (mac_valid_input) acc <= acc + w_q * x_q;
  end
  assign mac_out = acc[OUTW-1:0];

  // Control-pulse counters.
  int n_clr = 0, n_vin = 0, n_ovl = 0, n_done = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (mac_clear_acc) n_clr++;
      if (mac_valid_input) n_vin++;
      if (mac_clear_acc && mac_valid_input) n_ovl++;
    end
  end
  always @(posedge clk) if (!reset && done) n_done++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint sdata();
    return longint'($signed(out_data));
  endfunction

  function automatic longint apply_relu(input longint v);
`ifdef MAC_SEQ_CTRL_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: dot product of row r with x, from the memory contents.
  function automatic longint ref_row(input int r);
    longint s = 0;
    for (int c = 0; c < int'(N); c++) s += wmem[r * int'(N) + c] * xmem[c];
    return apply_relu(s);
  endfunction

  typedef struct packed {
    logic [5:0][15:0] w;
    logic [2:0][15:0] x;
    logic [1:0][31:0] y;
  } vec_t;

  function automatic vec_t mk(input int w0, input int w1, input int w2,
                              input int w3, input int w4, input int w5,
                              input int x0, input int x1, input int x2,
                              input int y0, input int y1);
    vec_t v;
    v.w[0] = 16'(w0); v.w[1] = 16'(w1); v.w[2] = 16'(w2);
    v.w[3] = 16'(w3); v.w[4] = 16'(w4); v.w[5] = 16'(w5);
    v.x[0] = 16'(x0); v.x[1] = 16'(x1); v.x[2] = 16'(x2);
    v.y[0] = 32'(y0); v.y[1] = 32'(y1);
    return v;
  endfunction

  longint exp_y [0:1];

  task automatic load(input vec_t v);
    for (int i = 0; i < 6; i++) wmem[i] = longint'($signed(v.w[i]));
    for (int i = 0; i < 3; i++) xmem[i] = longint'($signed(v.x[i]));
    for (int r = 0; r < 2; r++) exp_y[r] = apply_relu(longint'($signed(v.y[r])));
  endtask

  task automatic do_run(input int stall, input bit mid_start);
    int cyc;
    int c0, v0, o0, d0;
    c0 = n_clr; v0 = n_vin; o0 = n_ovl; d0 = n_done;
    out_ready = (stall == 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int r = 0; r < int'(M); r++) begin
      cyc = 1;
      while (!out_valid && cyc < 60) begin
        start = (mid_start && r == 0 && cyc == 3);
        @(negedge clk);
        cyc++;
      end
      start = 1'b0;
      if (!out_valid) begin
        chk("valid_timeout", 0, 1);
        return;
      end
      chk("latency", cyc, N + 3);
      chk("data", sdata(), exp_y[r]);
      chk("addr_w_hold", addr_w, r * int'(N) + int'(N) - 1);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", sdata(), exp_y[r]);
        chk("stall_addr_w", addr_w, r * int'(N) + int'(N) - 1);
        chk("stall_addr_x", addr_x, N - 1);
        chk("stall_done", done, 0);
      end
      out_ready = 1'b1;
      #1;
      chk("done", done, (r == int'(M) - 1));
      @(negedge clk);
      out_ready = (stall == 0);
      chk("post_valid", out_valid, 0);
      chk("post_busy", busy, (r != int'(M) - 1));
    end
    chk("clear_count", n_clr - c0, M);
    chk("vin_count", n_vin - v0, M * N);
    chk("ctrl_overlap", n_ovl - o0, 0);
    chk("done_count", n_done - d0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr_w"}, addr_w, 0);
    chk({tag, "_addr_x"}, addr_x, 0);
    chk({tag, "_clear"}, mac_clear_acc, 0);
    chk({tag, "_vin"}, mac_valid_input, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, sdata(), 0);
  endtask

  vec_t tbl [4];

  initial begin
    tbl[0] = mk( 1,  2,  3,  4,  5,  6,  1,  1, 1,  6, 15);
    tbl[1] = mk(-2, -3,  1,  4,  5,  6,  1,  1, 1, -4, 15);
    tbl[2] = mk( 1,  0,  0,  0,  0,  1,  7,  8, 9,  7,  9);
    tbl[3] = mk( 2,  2,  2, -1, -1, -1,  3, -4, 5,  8, -4);
    for (int i = 0; i < 8; i++) wmem[i] = 0;
    for (int i = 0; i < 4; i++) xmem[i] = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    // Table vectors, out_ready held high.
    for (int t = 0; t < 4; t++) begin
      load(tbl[t]);
      do_run(0, 1'b0);
    end

    // Backpressure: 5 stalled cycles per row.
    load(tbl[0]);
    do_run(5, 1'b0);

    // Start pulsed mid-RUN is ignored: two results, then idle.
    do_run(0, 1'b1);
    begin
      int extra = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (out_valid || busy) extra++;
      end
      chk("idle_after_run", extra, 0);
    end

    // Reset mid-RUN at row 0, col 1.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrun_addr_x", addr_x, 1);
    chk("midrun_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("after_reset");
    do_run(0, 1'b0);

    // start and reset together: reset wins.
    @(negedge clk); start = 1'b1; reset = 1'b1;
    @(negedge clk); start = 1'b0; reset = 1'b0;
    chk("reset_wins_busy", busy, 0);
    @(negedge clk);
    chk("reset_wins_idle", busy, 0);

    // Randomized runs against the reference model.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < int'(M * N); i++) wmem[i] = longint'($urandom_range(200)) - 100;
      for (int i = 0; i < int'(N); i++) xmem[i] = longint'($urandom_range(200)) - 100;
      for (int r = 0; r < int'(M); r++) exp_y[r] = ref_row(r);
      do_run(int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=%0d", checks, -1);
    $fatal(1, "timeout");
  end

endmodule
